// File: rtl/controller_tc_reset_pkg.sv
// Shared constants for the test-controller reset sequencer: register map,
// CTRL/STATUS bit positions and the sequencer state encoding.
package controller_tc_reset_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_HOLD   = 2'd2;
   localparam logic [1:0] ADDR_GAP    = 2'd3;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_ABORT_BIT = 1;

   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_DONE_BIT = 1;
   localparam int STAT_IDX_LSB  = 4;
   localparam int STAT_IDX_MSB  = 6;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

endpackage

// File: rtl/controller_tc_reset_timer.sv
// Loadable down-counter; expire_o pulses on the v-th edge after a load of v
// (a load of 0 behaves like 1). A load on the expiring edge restarts it.
module controller_tc_reset_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic [CNT_W-1:0] value_i,
   output logic             expire_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             active_q, active_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      active_d = active_q;
      if (clear_i) begin
         active_d = 1'b0;
      end else if (load_i) begin
         cnt_d    = (value_i == '0) ? CNT_W'(1) : value_i;
         active_d = 1'b1;
      end else if (active_q) begin
         if (cnt_q == CNT_W'(1)) begin
            active_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   assign expire_o = active_q && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/controller_tc_reset_sequencer.sv
// Memory-mapped reset sequencer: holds all reset lines, then releases them
// lowest index first with a programmable hold time and inter-release gap.
module controller_tc_reset_sequencer
   import controller_tc_reset_pkg::*;
#(
   parameter int NUM_RESETS  = 4,
   parameter int CNT_W       = 16,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [NUM_RESETS-1:0] out_port,
   output logic [1:0]            dbg_state_o
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_RESETS - 1);

   state_e                state_q, state_d;
   logic [NUM_RESETS-1:0] out_q, out_d;
   logic [2:0]            idx_q, idx_d;
   logic                  done_q, done_d;
   logic [CNT_W-1:0]      hold_q, hold_d;
   logic [CNT_W-1:0]      gap_q, gap_d;

   logic                  wr_en;
   logic                  start_req;
   logic                  abort_req;
   logic                  done_clr;
   logic                  busy;
   logic                  tmr_load;
   logic                  tmr_clear;
   logic [CNT_W-1:0]      tmr_value;
   logic                  tmr_expire;
   logic [NUM_RESETS-1:0] rel_mask;
   logic                  unused_wdata;

   assign wr_en     = chipselect && !write_n;
   assign start_req = wr_en && (address == ADDR_CTRL) && writedata[CTRL_START_BIT];
   assign abort_req = wr_en && (address == ADDR_CTRL) && writedata[CTRL_ABORT_BIT];
   assign done_clr  = wr_en && (address == ADDR_STATUS) && writedata[STAT_DONE_BIT];
   assign busy      = (state_q != ST_IDLE);
   assign rel_mask  = NUM_RESETS'(1) << idx_q;
   assign unused_wdata = ^writedata;

   controller_tc_reset_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (reset_n),
      .load_i   (tmr_load),
      .clear_i  (tmr_clear),
      .value_i  (tmr_value),
      .expire_o (tmr_expire)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         out_q   <= '1;
         idx_q   <= '0;
         done_q  <= 1'b0;
         hold_q  <= CNT_W'(HOLD_CYCLES);
         gap_q   <= CNT_W'(GAP_CYCLES);
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      idx_d     = idx_q;
      done_d    = done_q;
      hold_d    = hold_q;
      gap_d     = gap_q;
      tmr_load  = 1'b0;
      tmr_clear = 1'b0;
      tmr_value = gap_q;

      if (done_clr) begin
         done_d = 1'b0;
      end
      if (wr_en && !busy) begin
         if (address == ADDR_HOLD) hold_d = writedata[CNT_W-1:0];
         if (address == ADDR_GAP)  gap_d  = writedata[CNT_W-1:0];
      end

      // ABORT outranks everything, including a START in the same write.
      if (abort_req) begin
         state_d   = ST_IDLE;
         out_d     = '1;
         idx_d     = '0;
         tmr_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_req) begin
                  state_d   = ST_ASSERT;
                  out_d     = '1;
                  idx_d     = '0;
                  done_d    = 1'b0;
                  tmr_load  = 1'b1;
                  tmr_value = hold_q;
               end
            end
            // The end of the hold is simply the release of line 0.
            ST_ASSERT, ST_RELEASE: begin
               if (tmr_expire) begin
                  out_d = out_q & ~rel_mask;
                  idx_d = idx_q + 3'd1;
                  if (idx_q == LAST_IDX) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d   = ST_RELEASE;
                     tmr_load  = 1'b1;
                     tmr_value = gap_q;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL: readdata = 32'(out_q);
         ADDR_STATUS: begin
            readdata[STAT_BUSY_BIT]               = busy;
            readdata[STAT_DONE_BIT]               = done_q;
            readdata[STAT_IDX_MSB:STAT_IDX_LSB]   = idx_q;
         end
         ADDR_HOLD: readdata = 32'(hold_q);
         ADDR_GAP:  readdata = 32'(gap_q);
         default:   readdata = '0;
      endcase
   end

   assign out_port    = out_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_controller_tc_reset_sequencer.sv
// Self-checking bench for the reset sequencer: out_port timing is predicted
// per cycle into a queue at stimulus time and compared one edge at a time.
module tb_controller_tc_reset_sequencer;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_HOLD   = 2'd2;
   localparam logic [1:0] A_GAP    = 2'd3;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  out_port;
   logic [1:0]  dbg_state;

   logic [31:0] exp_q[$];
   int          checks;
   int          errors;

   controller_tc_reset_sequencer #(
      .NUM_RESETS  (4),
      .CNT_W       (16),
      .HOLD_CYCLES (16),
      .GAP_CYCLES  (8)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .out_port    (out_port),
      .dbg_state_o (dbg_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Independent timing model: line j is clear once k >= hold + j*gap.
   function automatic logic [31:0] model_out(int k, int h, int g);
      logic [31:0] m;
      int hh;
      int gg;
      m  = 32'hF;
      hh = (h == 0) ? 1 : h;
      gg = (g == 0) ? 1 : g;
      for (int j = 0; j < 4; j++) begin
         if (k >= hh + j * gg) m[j] = 1'b0;
      end
      return m;
   endfunction

   task automatic push_seq(int h, int g, int n);
      for (int k = 0; k <= n; k++) exp_q.push_back(model_out(k, h, g));
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = A_CTRL;
      writedata  = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      bus_read(A_CTRL, rd);
      checks++;
      if (rd !== 32'hF) begin errors++; $display("FAIL reset_ctrl got %h exp %h", rd, 32'hF); end
      bus_read(A_STATUS, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp %h", rd, 32'h0); end
      bus_read(A_HOLD, rd);
      checks++;
      if (rd !== 32'd16) begin errors++; $display("FAIL reset_hold got %h exp %h", rd, 32'd16); end
      bus_read(A_GAP, rd);
      checks++;
      if (rd !== 32'd8) begin errors++; $display("FAIL reset_gap got %h exp %h", rd, 32'd8); end
      checks++;
      if (out_port !== 4'hF) begin errors++; $display("FAIL reset_out got %h exp %h", out_port, 4'hF); end
   endtask

   task automatic test_default_sequence();
      logic [31:0] rd;
      logic [31:0] exp;
      push_seq(16, 8, 44);
      bus_write(A_CTRL, 32'h1);
      for (int k = 0; k <= 44; k++) begin
         if (k > 0) step();
         exp = exp_q.pop_front();
         checks++;
         if ({28'b0, out_port} !== exp) begin
            errors++;
            $display("FAIL default_out k=%0d got %h exp %h", k, out_port, exp);
         end
         if (k == 39) begin
            bus_read(A_STATUS, rd);
            checks++;
            if (rd !== 32'h31) begin errors++; $display("FAIL default_busy_k39 got %h exp %h", rd, 32'h31); end
         end
         if (k == 40) begin
            bus_read(A_STATUS, rd);
            checks++;
            if ((rd & 32'h3) !== 32'h2) begin errors++; $display("FAIL default_done_k40 got %h exp %h", rd & 32'h3, 32'h2); end
         end
      end
   endtask

   task automatic test_zero_timers();
      logic [31:0] rd;
      logic [31:0] exp;
      bus_write(A_HOLD, 32'h0);
      bus_write(A_GAP, 32'h0);
      push_seq(0, 0, 6);
      bus_write(A_CTRL, 32'h1);
      for (int k = 0; k <= 6; k++) begin
         if (k > 0) step();
         exp = exp_q.pop_front();
         checks++;
         if ({28'b0, out_port} !== exp) begin
            errors++;
            $display("FAIL zero_out k=%0d got %h exp %h", k, out_port, exp);
         end
      end
      bus_read(A_STATUS, rd);
      checks++;
      if ((rd & 32'h3) !== 32'h2) begin errors++; $display("FAIL zero_done got %h exp %h", rd & 32'h3, 32'h2); end
      bus_write(A_HOLD, 32'd16);
      bus_write(A_GAP, 32'd8);
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      logic [31:0] exp;
      push_seq(16, 8, 19);
      bus_write(A_CTRL, 32'h1);
      for (int k = 0; k <= 19; k++) begin
         if (k > 0) step();
         exp = exp_q.pop_front();
         checks++;
         if ({28'b0, out_port} !== exp) begin
            errors++;
            $display("FAIL abort_pre_out k=%0d got %h exp %h", k, out_port, exp);
         end
      end
      bus_write(A_CTRL, 32'h3);
      checks++;
      if (out_port !== 4'hF) begin errors++; $display("FAIL abort_out got %h exp %h", out_port, 4'hF); end
      bus_read(A_STATUS, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL abort_status got %h exp %h", rd, 32'h0); end
      repeat (30) step();
      checks++;
      if (out_port !== 4'hF) begin errors++; $display("FAIL abort_stays_out got %h exp %h", out_port, 4'hF); end
      bus_write(A_HOLD, 32'd5);
      bus_read(A_HOLD, rd);
      checks++;
      if (rd !== 32'd5) begin errors++; $display("FAIL abort_hold_wr got %h exp %h", rd, 32'd5); end
      bus_write(A_HOLD, 32'd16);
      // START together with ABORT while idle must not start anything.
      bus_write(A_CTRL, 32'h3);
      repeat (20) step();
      bus_read(A_STATUS, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL start_abort_status got %h exp %h", rd, 32'h0); end
      checks++;
      if (out_port !== 4'hF) begin errors++; $display("FAIL start_abort_out got %h exp %h", out_port, 4'hF); end
   endtask

   task automatic test_busy_writes();
      logic [31:0] rd;
      logic [31:0] exp;
      push_seq(16, 8, 44);
      bus_write(A_CTRL, 32'h1);
      for (int k = 0; k <= 44; k++) begin
         if (k == 5)       bus_write(A_HOLD, 32'd100);
         else if (k == 10) bus_write(A_CTRL, 32'h1);
         else if (k == 40) bus_write(A_STATUS, 32'h2);
         else if (k > 0)   step();
         exp = exp_q.pop_front();
         checks++;
         if ({28'b0, out_port} !== exp) begin
            errors++;
            $display("FAIL busy_out k=%0d got %h exp %h", k, out_port, exp);
         end
      end
      bus_read(A_HOLD, rd);
      checks++;
      if (rd !== 32'd16) begin errors++; $display("FAIL busy_hold_locked got %h exp %h", rd, 32'd16); end
      bus_read(A_STATUS, rd);
      checks++;
      if ((rd & 32'h3) !== 32'h2) begin errors++; $display("FAIL done_set_wins got %h exp %h", rd & 32'h3, 32'h2); end
      bus_write(A_STATUS, 32'h2);
      bus_read(A_STATUS, rd);
      checks++;
      if ((rd & 32'h3) !== 32'h0) begin errors++; $display("FAIL done_clear got %h exp %h", rd & 32'h3, 32'h0); end
   endtask

   task automatic test_reset_mid_sequence();
      logic [31:0] rd;
      logic [31:0] exp;
      push_seq(16, 8, 25);
      bus_write(A_CTRL, 32'h1);
      for (int k = 0; k <= 25; k++) begin
         if (k > 0) step();
         exp = exp_q.pop_front();
         checks++;
         if ({28'b0, out_port} !== exp) begin
            errors++;
            $display("FAIL rst_pre_out k=%0d got %h exp %h", k, out_port, exp);
         end
      end
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_port !== 4'hF) begin errors++; $display("FAIL rst_mid_out got %h exp %h", out_port, 4'hF); end
      bus_read(A_STATUS, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL rst_mid_status got %h exp %h", rd, 32'h0); end
      // Release reset and issue START so the very next edge accepts it.
      push_seq(16, 8, 44);
      @(negedge clk);
      reset_n    = 1'b1;
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = A_CTRL;
      writedata  = 32'h1;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      for (int k = 0; k <= 44; k++) begin
         if (k > 0) step();
         exp = exp_q.pop_front();
         checks++;
         if ({28'b0, out_port} !== exp) begin
            errors++;
            $display("FAIL rst_post_out k=%0d got %h exp %h", k, out_port, exp);
         end
      end
      bus_read(A_STATUS, rd);
      checks++;
      if ((rd & 32'h3) !== 32'h2) begin errors++; $display("FAIL rst_post_done got %h exp %h", rd & 32'h3, 32'h2); end
   endtask

   // Test sequence and final report
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_default_sequence();
      test_zero_timers();
      test_abort();
      test_busy_writes();
      test_reset_mid_sequence();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
